datamem_wait_resp: RTL and testbench
====================================

# datamem_wait_resp

Data-memory responder for the RV32IMV core's load/store port: it accepts one request at a time from the CPU (address, store data, 4-bit byte-write mask) and completes it after a programmable number of wait states. It answers with a one-cycle `ready` pulse and, for loads, a registered read word. It replaces the zero-latency check memory in system builds, so that the CPU's stall logic can be exercised against a slow memory.

## Interface
- `ADDR_BITS`, default 10: word-address width; the memory holds 2^ADDR_BITS 32-bit words.
- `WAIT`, default 2: wait states per access, legal range 0–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clrn`  in  1  reset; one clock, reset is synchronous and active-low.
- `req`  in  1  CPU request valid; held high with stable `addr`/`b`/`wmem` until `ready`.
- `addr`  in  32  byte address, usually the ALU output.
- `b`  in  32  store data, byte lanes aligned to the word.
- `wmem`  in  4  byte write enables; bit i writes `b[8i+7:8i]`; 4'b0000 means load.
- `mem`  out  32  read word; registered.
- `ready`  out  1  one-cycle completion pulse.

## Operation
- FSM has three states.
  - IDLE: `req`=1 at an edge captures `addr[ADDR_BITS+1:2]`, `b` and `wmem`, and loads `cnt`=WAIT. The next state is BUSY if WAIT>0, otherwise DONE.
  - BUSY: `cnt` decrements each edge. When `cnt`=1 the next state is DONE.
  - DONE: the access is performed at the edge entering DONE. `ready`=1 for the whole DONE cycle, then the FSM returns to IDLE unconditionally.
- Address handling:
  - `addr[1:0]` is ignored.
  - Address bits above ADDR_BITS+1 are ignored, so accesses wrap modulo the array size.
- Store (`wmem`≠0): only the enabled bytes are written. `mem` keeps its previous value.
- Load (`wmem`=0): `mem` is loaded with the full word at the captured address.
- Captured request:
  - Inputs are sampled only in IDLE. Changes to `req`, `addr`, `b` or `wmem` during BUSY/DONE have no effect.
  - `req` seen during DONE is ignored. The CPU's held `req` is accepted again at the IDLE edge. The CPU must drop `req` in the cycle after `ready`, or it issues a new request.
- Reset: `clrn`=0 at an edge gives state=IDLE, `cnt`=0, `ready`=0, `mem`=0.
  - A reset during BUSY aborts the access: no array write occurs, because the write happens only on entry to DONE.
  - Array contents are not reset.
- Read-after-write: a load issued after a store to the same word returns the merged word.

## Timing
- Request first sampled at edge E0. `ready` and valid `mem` are visible in the cycle after edge E0+WAIT, so latency is WAIT+1 cycles.
- With WAIT=0, `ready` is high in the cycle directly after the accepting edge.
- The earliest next accept is the IDLE edge after DONE. Back-to-back throughput is one access per WAIT+2 cycles.
- `ready` is never high for two consecutive cycles.
- `mem` changes only on load completion or reset.

## Structure
- Shared package `rv32imv_mem_pkg`:
  - FSM state enum {IDLE, BUSY, DONE}.
  - `WMEM_LOAD`=4'b0000, `WMEM_WORD`=4'b1111.
  - Byte-lane masks for SB/SH.
- One sub-module, `dmem_bytelane_ram`: a synchronous 2^ADDR_BITS×32 array with a per-byte write enable and a registered read port.
- The FSM and counter live in the top module.

## Test plan
- Reset then idle:
  - Stimulus: `clrn`=0 for 2 cycles, `req`=0.
  - Required: `ready`=0, `mem`=0x00000000 for all cycles.
- Word store then load, WAIT=2:
  - Stimulus: store `addr`=0x10, `b`=0xDEADBEEF, `wmem`=4'hF; then load from 0x10.
  - Required: `ready` pulses 3 cycles after each accept; load gives `mem`=0xDEADBEEF.
- Byte merge:
  - Stimulus: after the word store above, store `addr`=0x12, `b`=0x00AA0000, `wmem`=4'b0100; then load from 0x10.
  - Required: `mem`=0xDEAABEEF; `mem` unchanged during the store.
- Wrap-around, ADDR_BITS=10:
  - Stimulus: store 0x12345678 at 0x1000; load from 0x0000.
  - Required: `mem`=0x12345678.
- Reset mid-access:
  - Stimulus: store 0xFFFFFFFF at 0x20 (location previously 0x01020304); assert `clrn`=0 during BUSY.
  - Required: no `ready` pulse; a subsequent load of 0x20 returns 0x01020304.
- WAIT=0 with held `req`:
  - Stimulus: keep `req`=1 continuously on a load.
  - Required: `ready` pulses every 2nd cycle; input changes made during DONE are not captured.

Source files
------------

// File: rtl/rv32imv_mem_pkg.sv
// Shared types and constants for the RV32IMV data-memory responders.
// Holds the responder FSM states and the byte-write mask encodings.
package rv32imv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] WMEM_LOAD = 4'b0000;
  localparam logic [3:0] WMEM_WORD = 4'b1111;
  localparam logic [3:0] WMEM_SB   = 4'b0001;
  localparam logic [3:0] WMEM_SH   = 4'b0011;

  // Shift a base SB/SH mask into the lane selected by the low address bits.
  function automatic logic [3:0] lane_mask(input logic [3:0] base, input logic [1:0] offset);
    return base << offset;
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// 2^ADDR_BITS x 32 synchronous RAM with per-byte write enables and a
// registered read port that only updates on a read and clears on reset.
module dmem_bytelane_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 rd_en,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] ram_q [2**ADDR_BITS];
  logic [31:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        ram_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      rdata_q <= 32'h0;
    end else if (rd_en) begin
      rdata_q <= ram_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/datamem_wait_resp.sv
// Data-memory responder with WAIT programmable wait states: captures one CPU
// request in IDLE, counts down in BUSY, performs the access entering DONE.
module datamem_wait_resp
  import rv32imv_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int WAIT      = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] b,
  input  logic [3:0]  wmem,
  output logic [31:0] mem,
  output logic        ready
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            b_q, b_d;
  logic [3:0]             wmem_q, wmem_d;

  logic                   acc_en;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [31:0]            acc_b;
  logic [3:0]             acc_wmem;
  logic                   ram_rd_en;
  logic [3:0]             ram_we;

  logic                   unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_BITS+2], addr[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    b_d      = b_q;
    wmem_d   = wmem_q;
    acc_en   = 1'b0;
    acc_addr = addr_q;
    acc_b    = b_q;
    acc_wmem = wmem_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = addr[ADDR_BITS+1:2];
          b_d    = b;
          wmem_d = wmem;
          cnt_d  = WAIT_CNT;
          if (WAIT_CNT == 4'd0) begin
            // No wait states: the access happens on this same edge, so it
            // must use the live inputs rather than the not-yet-captured copy.
            state_d  = DONE;
            acc_en   = 1'b1;
            acc_addr = addr[ADDR_BITS+1:2];
            acc_b    = b;
            acc_wmem = wmem;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          acc_en  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      b_q     <= 32'h0;
      wmem_q  <= WMEM_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      b_q     <= b_d;
      wmem_q  <= wmem_d;
    end
  end

  // Gating with clrn means a reset on the DONE-entry edge aborts the write.
  assign ram_rd_en = acc_en && clrn && (acc_wmem == WMEM_LOAD);
  assign ram_we    = (acc_en && clrn) ? acc_wmem : WMEM_LOAD;

  dmem_bytelane_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .clrn  (clrn),
    .rd_en (ram_rd_en),
    .we    (ram_we),
    .addr  (acc_addr),
    .wdata (acc_b),
    .rdata (mem)
  );

  assign ready = (state_q == DONE);

endmodule

// File: tb/tb_datamem_wait_resp.sv
// Scoreboard bench for datamem_wait_resp: one instance with WAIT=2 and one
// with WAIT=0; per-instance monitors compare ready timing and mem values.
module tb_datamem_wait_resp;

  typedef struct {
    logic [31:0] mem;
    int          cyc;
    bit          load;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;

  logic        req2 = 1'b0;
  logic [31:0] addr2 = '0, b2 = '0;
  logic [3:0]  wmem2 = '0;
  logic [31:0] mem2;
  logic        ready2;

  logic        req0 = 1'b0;
  logic [31:0] addr0 = '0, b0 = '0;
  logic [3:0]  wmem0 = '0;
  logic [31:0] mem0;
  logic        ready0;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  bit   rst_seen = 1'b0;

  exp_t q2[$];
  exp_t q0[$];
  logic [31:0] mexp2 = '0, mexp0 = '0;
  logic        prev2 = 1'b0, prev0 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= clrn;
  end

  datamem_wait_resp #(.ADDR_BITS(10), .WAIT(2)) dut (
    .clk(clk), .clrn(clrn), .req(req2), .addr(addr2), .b(b2), .wmem(wmem2),
    .mem(mem2), .ready(ready2)
  );

  datamem_wait_resp #(.ADDR_BITS(10), .WAIT(0)) dut0 (
    .clk(clk), .clrn(clrn), .req(req0), .addr(addr0), .b(b0), .wmem(wmem0),
    .mem(mem0), .ready(ready0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // Monitor for the WAIT=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      chk("w2_reset_ready", {31'b0, ready2}, 32'h0);
      chk("w2_reset_mem", mem2, 32'h0);
      q2.delete();
      mexp2 = '0;
      prev2 = 1'b0;
    end else begin
      if (ready2 && prev2) chk("w2_ready_twice", 32'h1, 32'h0);
      if (ready2) begin
        if (q2.size() == 0) begin
          chk("w2_spurious_ready", {31'b0, ready2}, 32'h0);
        end else begin
          e = q2.pop_front();
          chk("w2_ready_cycle", cyc, e.cyc);
          if (e.load) mexp2 = e.mem;
          chk(e.load ? "w2_load_mem" : "w2_store_mem_hold", mem2, mexp2);
        end
      end else begin
        chk("w2_mem_stable", mem2, mexp2);
      end
      prev2 = ready2;
    end
  end

  // Monitor for the WAIT=0 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      chk("w0_reset_ready", {31'b0, ready0}, 32'h0);
      chk("w0_reset_mem", mem0, 32'h0);
      q0.delete();
      mexp0 = '0;
      prev0 = 1'b0;
    end else begin
      if (ready0 && prev0) chk("w0_ready_twice", 32'h1, 32'h0);
      if (ready0) begin
        if (q0.size() == 0) begin
          chk("w0_spurious_ready", {31'b0, ready0}, 32'h0);
        end else begin
          e = q0.pop_front();
          chk("w0_ready_cycle", cyc, e.cyc);
          if (e.load) mexp0 = e.mem;
          chk(e.load ? "w0_load_mem" : "w0_store_mem_hold", mem0, mexp0);
        end
      end else begin
        chk("w0_mem_stable", mem0, mexp0);
      end
      prev0 = ready0;
    end
  end

  task automatic access2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         input logic [31:0] exp_mem);
    bit got;
    @(posedge clk); #1;
    req2 = 1'b1; addr2 = a; b2 = d; wmem2 = w;
    q2.push_back('{mem: exp_mem, cyc: cyc + 1 + 2, load: (w == 4'h0)});
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready2) got = 1'b1;
    end
    if (!got) chk("w2_ready_timeout", 32'h0, 32'h1);
    req2 = 1'b0;
  endtask

  task automatic access0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         input logic [31:0] exp_mem);
    bit got;
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = a; b0 = d; wmem0 = w;
    q0.push_back('{mem: exp_mem, cyc: cyc + 1, load: (w == 4'h0)});
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready0) got = 1'b1;
    end
    if (!got) chk("w0_ready_timeout", 32'h0, 32'h1);
    req0 = 1'b0;
  endtask

  initial begin
    int c;
    // Reset held for two edges with no requests.
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    repeat (2) @(posedge clk);

    // Word store then load.
    access2(32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    access2(32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

    // Byte merge into lane 2.
    access2(32'h12, 32'h00AA0000, 4'b0100, 32'h0);
    access2(32'h10, 32'h0, 4'h0, 32'hDEAABEEF);

    // Address wrap: 0x1000 aliases word 0 with ADDR_BITS=10.
    access2(32'h1000, 32'h12345678, 4'hF, 32'h0);
    access2(32'h0, 32'h0, 4'h0, 32'h12345678);

    // Reset during BUSY aborts the store.
    access2(32'h20, 32'h01020304, 4'hF, 32'h0);
    @(posedge clk); #1;
    req2 = 1'b1; addr2 = 32'h20; b2 = 32'hFFFFFFFF; wmem2 = 4'hF;
    @(posedge clk); #1;
    clrn = 1'b0; req2 = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    access2(32'h20, 32'h0, 4'h0, 32'h01020304);

    // WAIT=0: seed a word, then hold req on loads; a store pattern placed
    // on the inputs only during DONE must not be captured.
    access0(32'h40, 32'hCAFEF00D, 4'hF, 32'h0);
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'h40; b0 = 32'h0; wmem0 = 4'h0;
    c = cyc + 1;
    q0.push_back('{mem: 32'hCAFEF00D, cyc: c,     load: 1'b1});
    q0.push_back('{mem: 32'hCAFEF00D, cyc: c + 2, load: 1'b1});
    q0.push_back('{mem: 32'hCAFEF00D, cyc: c + 4, load: 1'b1});
    @(posedge clk); #1;
    b0 = 32'hBAD0BAD0; wmem0 = 4'hF;
    @(posedge clk); #1;
    b0 = 32'h0; wmem0 = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req0 = 1'b0;
    access0(32'h40, 32'h0, 4'h0, 32'hCAFEF00D);

    repeat (4) @(posedge clk);
    #1;
    chk("w2_scoreboard_drained", q2.size(), 32'h0);
    chk("w0_scoreboard_drained", q0.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
